// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the registered pipeline chain.
package pipe_reg_chain_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_DEPTH = 3;

  // Ceiling log2, used to size the occupancy counter.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < n) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One pipeline stage: a data register plus its valid bit, moving only on advance.
module pipe_reg_chain_stage
  import pipe_reg_chain_pkg::*;
#(
  parameter int unsigned     WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             adv,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  logic             valid_d;
  logic [WIDTH-1:0] data_d;

  // Next state: flush clears valid only; bubbles never overwrite data.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= RESET_DATA;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage registered valid/ready pipeline with flush and occupancy count.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEF_WIDTH,
  parameter int unsigned      DEPTH      = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  localparam int unsigned     CW         = clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  output logic             Din_ready,
  output logic [WIDTH-1:0] Dout,
  output logic             Dout_valid,
  input  logic             Dout_ready,
  input  logic             Flush,
  output logic [CW-1:0]    Count
);

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] stage_v;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic             adv_run;
  logic             in_fire;
  logic             out_fire;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  // Combinational ready chain from the sink back to the head stage.
  always_comb begin
    adv     = '0;
    adv_run = Dout_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      adv_run = ~stage_v[k] | adv_run;
      adv[k]  = adv_run;
    end
  end

  assign Din_ready = adv[0] & ~Flush;
  assign in_fire   = Din_valid & Din_ready;
  assign out_fire  = stage_v[DEPTH-1] & Dout_ready;

  // Stage instances; stage 0 takes the accepted input word.
  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    if (k == 0) begin : g_head
      assign in_valid = in_fire;
      assign in_data  = Din;
    end else begin : g_link
      assign in_valid = stage_v[k-1];
      assign in_data  = stage_data[k-1];
    end
    pipe_reg_chain_stage #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_stage (
      .clk      (CLK),
      .rst_n    (RSTn),
      .flush    (Flush),
      .adv      (adv[k]),
      .in_valid (in_valid),
      .in_data  (in_data),
      .valid_q  (stage_v[k]),
      .data_q   (stage_data[k])
    );
  end

  // Occupancy: +1 per accepted word, -1 per delivered word, cleared by flush.
  always_comb begin
    count_d = count_q + CW'(in_fire) - CW'(out_fire);
    if (Flush) begin
      count_d = '0;
    end
  end

  // Occupancy register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Dout       = stage_data[DEPTH-1];
  assign Dout_valid = stage_v[DEPTH-1];
  assign Count      = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed self-checking bench for pipe_reg_chain (WIDTH=4, DEPTH=3).
module tb_pipe_reg_chain;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       flush;
  logic [1:0] count;

  int total;
  int bad;

  pipe_reg_chain #(
    .WIDTH      (4),
    .DEPTH      (3),
    .RESET_DATA (4'h0)
  ) dut (
    .CLK        (clk),
    .RSTn       (rst_n),
    .Din        (din),
    .Din_valid  (din_valid),
    .Din_ready  (din_ready),
    .Dout       (dout),
    .Dout_valid (dout_valid),
    .Dout_ready (dout_ready),
    .Flush      (flush),
    .Count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    din        = 4'h0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    flush      = 1'b0;

    // Reset state
    #2;
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd1);
    #20;
    rst_n = 1'b1;
    tick();

    // Latency: single word appears after exactly 3 edges
    din = 4'hA; din_valid = 1'b1; dout_ready = 1'b1;
    tick();
    din_valid = 1'b0; din = 4'h0;
    check("lat_v_e0", 32'(dout_valid), 32'd0);
    check("lat_cnt_e0", 32'(count), 32'd1);
    tick();
    check("lat_v_e1", 32'(dout_valid), 32'd0);
    check("lat_cnt_e1", 32'(count), 32'd1);
    tick();
    check("lat_v_e2", 32'(dout_valid), 32'd1);
    check("lat_dout_e2", 32'(dout), 32'hA);
    check("lat_cnt_e2", 32'(count), 32'd1);
    tick();
    check("lat_v_e3", 32'(dout_valid), 32'd0);
    check("lat_cnt_e3", 32'(count), 32'd0);
    check("lat_dout_hold", 32'(dout), 32'hA);

    // Streaming 1..8 back to back
    for (int c = 0; c < 11; c++) begin
      if (c < 8) begin
        din = 4'(c + 1); din_valid = 1'b1;
      end else begin
        din_valid = 1'b0;
      end
      #1;
      check("stream_din_ready", 32'(din_ready), 32'd1);
      tick();
      if (c >= 2 && c <= 9) begin
        check("stream_dout_valid", 32'(dout_valid), 32'd1);
        check("stream_dout", 32'(dout), 32'(c - 1));
      end
      if (c >= 2 && c <= 7) check("stream_count", 32'(count), 32'd3);
    end
    check("stream_end_valid", 32'(dout_valid), 32'd0);
    check("stream_end_count", 32'(count), 32'd0);

    // Backpressure: fill with 1,2,3 while sink stalls
    dout_ready = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      din = 4'(n); din_valid = 1'b1;
      #1;
      check("bp_fill_ready", 32'(din_ready), 32'd1);
      tick();
    end
    din = 4'h4;
    #1;
    check("bp_full_ready", 32'(din_ready), 32'd0);
    check("bp_full_count", 32'(count), 32'd3);
    check("bp_full_dout", 32'(dout), 32'd1);
    tick();
    tick();
    check("bp_hold_dout", 32'(dout), 32'd1);
    check("bp_hold_count", 32'(count), 32'd3);
    check("bp_hold_ready", 32'(din_ready), 32'd0);

    // Full pass-through: sink ready re-enables input in the same cycle
    dout_ready = 1'b1;
    #1;
    check("pt_din_ready", 32'(din_ready), 32'd1);
    tick();
    check("pt_count", 32'(count), 32'd3);
    check("pt_dout", 32'(dout), 32'd2);
    din = 4'h5;
    tick();
    din_valid = 1'b0;
    check("drain_dout3", 32'(dout), 32'd3);
    check("drain_cnt3", 32'(count), 32'd3);
    tick();
    check("drain_dout4", 32'(dout), 32'd4);
    check("drain_cnt4", 32'(count), 32'd2);
    tick();
    check("drain_dout5", 32'(dout), 32'd5);
    check("drain_v5", 32'(dout_valid), 32'd1);
    check("drain_cnt5", 32'(count), 32'd1);
    tick();
    check("drain_end_v", 32'(dout_valid), 32'd0);
    check("drain_end_cnt", 32'(count), 32'd0);

    // Flush with two words in flight and a pending input
    din = 4'h6; din_valid = 1'b1;
    tick();
    din = 4'h7;
    tick();
    check("fl_pre_count", 32'(count), 32'd2);
    flush = 1'b1; din = 4'h9;
    #1;
    check("fl_din_ready", 32'(din_ready), 32'd0);
    tick();
    flush = 1'b0; din_valid = 1'b0;
    check("fl_count", 32'(count), 32'd0);
    check("fl_dout_valid", 32'(dout_valid), 32'd0);
    check("fl_dout_hold", 32'(dout), 32'd5);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("fl_no_output", 32'(dout_valid), 32'd0);
    end

    // Async reset mid-stream with three words held
    dout_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      din = 4'(4'hC + n); din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    check("ar_pre_count", 32'(count), 32'd3);
    check("ar_pre_dout", 32'(dout), 32'hC);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_dout_valid", 32'(dout_valid), 32'd0);
    check("ar_count", 32'(count), 32'd0);
    check("ar_dout", 32'(dout), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    din = 4'hB; din_valid = 1'b1; dout_ready = 1'b1;
    tick();
    din_valid = 1'b0;
    check("ar_lat_e0", 32'(dout_valid), 32'd0);
    tick();
    check("ar_lat_e1", 32'(dout_valid), 32'd0);
    tick();
    check("ar_lat_e2_v", 32'(dout_valid), 32'd1);
    check("ar_lat_e2_d", 32'(dout), 32'hB);
    tick();
    check("ar_lat_e3_v", 32'(dout_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
